// File: rtl/flex_stp_framer.sv
// flex_stp_framer: serial-to-parallel framer with held word, valid/ready handshake and overrun flag (optional STP_PARITY_EN adds a trailing even-parity bit and parity_err)
module flex_stp_framer #(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 1,
  parameter int RESET_ONES = 1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clear,
  input  logic                          serial_in,
  input  logic                          shift_enable,
  output logic [NUM_BITS-1:0]           parallel_out,
  output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
  output logic [NUM_BITS-1:0]           word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          overrun
`ifdef STP_PARITY_EN
  , output logic                        parity_err
`endif
);
  localparam int CW = $clog2(NUM_BITS+1);
  localparam logic [NUM_BITS-1:0] RST_VAL = RESET_ONES != 0 ? '1 : '0;
`ifdef STP_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS);
`else
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS-1);
`endif
  logic [NUM_BITS-1:0] sr_next, cap;
  logic last, done, free, do_shift;
  // next shift value, frame-completion and holding-register availability
  always_comb begin
    sr_next  = SHIFT_MSB != 0 ? {parallel_out[NUM_BITS-2:0], serial_in} : {serial_in, parallel_out[NUM_BITS-1:1]};
    last     = bit_count == LAST;
    done     = shift_enable & last;
    free     = ~word_valid | word_ready;
`ifdef STP_PARITY_EN
    do_shift = shift_enable & ~last;
    cap      = parallel_out;
`else
    do_shift = shift_enable;
    cap      = sr_next;
`endif
  end
  // shift register, bit counter, holding register and sticky overrun
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= RST_VAL;
      bit_count    <= '0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
`ifdef STP_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else if (clear) begin
      parallel_out <= RST_VAL;
      bit_count    <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
`ifdef STP_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      if (do_shift) parallel_out <= sr_next;
      if (shift_enable) bit_count <= last ? '0 : bit_count + CW'(1);
      if (done && free) begin
        word_data  <= cap;
        word_valid <= 1'b1;
`ifdef STP_PARITY_EN
        parity_err <= (^parallel_out) ^ serial_in;
`endif
      end else begin
        if (word_valid && word_ready) word_valid <= 1'b0;
        if (done) overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_flex_stp_framer.sv
// tb_flex_stp_framer: directed self-checking bench for flex_stp_framer (MSB and LSB shift instances)
module tb_flex_stp_framer;
  logic clk = 1'b0, n_rst = 1'b0, clear = 1'b0, serial_in = 1'b0, shift_enable = 1'b0, word_ready = 1'b0;
  logic [7:0] po_m, wd_m, po_l, wd_l;
  logic [3:0] bc_m, bc_l;
  logic wv_m, ov_m, wv_l, ov_l;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
`ifdef STP_PARITY_EN
  logic pe_m, pe_l;
`endif
  flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(1), .RESET_ONES(1)) u_msb (
    .clk(clk), .n_rst(n_rst), .clear(clear), .serial_in(serial_in), .shift_enable(shift_enable),
    .parallel_out(po_m), .bit_count(bc_m), .word_data(wd_m), .word_valid(wv_m), .word_ready(word_ready), .overrun(ov_m)
`ifdef STP_PARITY_EN
    , .parity_err(pe_m)
`endif
  );
  flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(0), .RESET_ONES(1)) u_lsb (
    .clk(clk), .n_rst(n_rst), .clear(clear), .serial_in(serial_in), .shift_enable(shift_enable),
    .parallel_out(po_l), .bit_count(bc_l), .word_data(wd_l), .word_valid(wv_l), .word_ready(word_ready), .overrun(ov_l)
`ifdef STP_PARITY_EN
    , .parity_err(pe_l)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    serial_in = b;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps, input bit rdy_last, input logic rdy);
    word_ready = rdy;
    for (int i = 7; i >= 0; i--) begin
      if (gaps) repeat ((7 - i) % 4) tick();
`ifndef STP_PARITY_EN
      if (i == 0 && rdy_last) word_ready = 1'b1;
`endif
      send_bit(d[i]);
    end
`ifdef STP_PARITY_EN
    if (rdy_last) word_ready = 1'b1;
    send_bit(p);
`endif
    word_ready = rdy;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) tick();
    check("rst_po", po_m, 8'hFF);
    check("rst_bc", bc_m, 0);
    check("rst_wv", wv_m, 0);
    check("rst_ov", ov_m, 0);
    check("rst_wd", wd_m, 0);
    send_frame(8'hD0, ^8'hD0, 1'b0, 1'b0, 1'b1);
    check("d0_wv", wv_m, 1);
    check("d0_wd_msb", wd_m, 8'hD0);
    check("d0_wd_lsb", wd_l, 8'h0B);
    check("d0_po_msb", po_m, 8'hD0);
    check("d0_bc", bc_m, 0);
    tick();
    check("d0_wv_one_cycle", wv_m, 0);
    send_frame(8'hD0, ^8'hD0, 1'b1, 1'b0, 1'b1);
    check("gap_wd_msb", wd_m, 8'hD0);
    check("gap_wd_lsb", wd_l, 8'h0B);
    check("gap_wv", wv_m, 1);
    tick();
    check("gap_wv_fall", wv_m, 0);
    send_frame(8'h12, ^8'h12, 1'b0, 1'b0, 1'b0);
    check("ov_first_wd", wd_m, 8'h12);
    check("ov_first_ov", ov_m, 0);
    send_frame(8'h34, ^8'h34, 1'b1, 1'b0, 1'b0);
    check("ov_keep_wd", wd_m, 8'h12);
    check("ov_set", ov_m, 1);
    check("ov_wv", wv_m, 1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("ov_xfer_wv", wv_m, 0);
    check("ov_sticky", ov_m, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ov_clear", ov_m, 0);
    check("clr_wd_hold", wd_m, 8'h12);
    send_frame(8'h12, ^8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(8'h34, ^8'h34, 1'b0, 1'b1, 1'b0);
    check("same_edge_wd", wd_m, 8'h34);
    check("same_edge_wv", wv_m, 1);
    check("same_edge_ov", ov_m, 0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("same_edge_drain", wv_m, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("part_bc", bc_m, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_bc", bc_m, 0);
    check("clr_po", po_m, 8'hFF);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a5_wd", wd_m, 8'hA5);
    check("a5_wv", wv_m, 1);
`ifdef STP_PARITY_EN
    check("a5_par_ok", pe_m, 0);
`endif
    tick();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("part2_bc", bc_m, 3);
    #2 n_rst = 1'b0;
    #2 n_rst = 1'b1;
    check("nrst_bc", bc_m, 0);
    check("nrst_wd", wd_m, 0);
    check("nrst_po", po_m, 8'hFF);
    tick();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("a5b_wd_msb", wd_m, 8'hA5);
    check("a5b_wd_lsb", wd_l, 8'hA5);
`ifdef STP_PARITY_EN
    check("a5_par_err", pe_m, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
